// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port load/store sequencer with read-modify-write for a single-port word memory
module dmem_arbiter #(
  parameter int DEPTH_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [31:0]       addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [3:0]        be0,
  output logic              gnt0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [3:0]        be1,
  output logic              gnt1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE} state_t;
  state_t state, state_nx;
  logic last, owner, l_we, full, none;
  logic [DEPTH_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata, mbuf, merged;
  logic [3:0] l_be;
  logic unused;
  assign unused = ^{addr0[31:DEPTH_W+2], addr0[1:0], addr1[31:DEPTH_W+2], addr1[1:0]};
  assign full = l_be == 4'hF;
  assign none = l_be == 4'h0;
  assign gnt0 = rst && state == IDLE && req0 && (!req1 || last);
  assign gnt1 = rst && state == IDLE && req1 && (!req0 || !last);
  for (genvar i = 0; i < 4; i++) begin : g_merge
    assign merged[8*i +: 8] = l_be[i] ? l_wdata[8*i +: 8] : mbuf[8*i +: 8];
  end
  assign mem_we = state == MERGE || (state == ACCESS && l_we && full);
  assign mem_addr = {{(32-DEPTH_W){1'b0}}, l_addr};
  assign mem_wd = state == MERGE ? merged : l_wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE   ? ((gnt0 || gnt1) ? ACCESS : IDLE) :
               state == ACCESS ? ((l_we && !full && !none) ? MERGE : IDLE) : IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      last    <= 1'b1;
      owner   <= 1'b0;
      l_we    <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_be    <= '0;
      mbuf    <= '0;
      rdata   <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
    end else begin
      ack0 <= state != IDLE && state_nx == IDLE && !owner;
      ack1 <= state != IDLE && state_nx == IDLE && owner;
      if (gnt0 || gnt1) begin
        last    <= gnt1;
        owner   <= gnt1;
        l_we    <= gnt1 ? we1 : we0;
        l_addr  <= gnt1 ? addr1[DEPTH_W+1:2] : addr0[DEPTH_W+1:2];
        l_wdata <= gnt1 ? wdata1 : wdata0;
        l_be    <= gnt1 ? be1 : be0;
      end
      if (state == ACCESS) mbuf <= mem_rd;
      if (state == ACCESS && !l_we) rdata <= mem_rd;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a word-array reference model
module tb_dmem_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic [3:0] be0 = 0, be1 = 0;
  logic gnt0, ack0, gnt1, ack1, mem_we;
  logic [31:0] rdata, mem_addr, mem_wd, mem_rd;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic pl_en = 1'b0;
  logic [9:0] pl_a = '0;
  logic [31:0] pl_d = '0;
  logic [31:0] exp_rd = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .be0(be0), .gnt0(gnt0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .be1(be1), .gnt1(gnt1), .ack1(ack1),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );
  always @(posedge clk)
    if (pl_en) mem[pl_a] <= pl_d;
    else if (mem_we) mem[mem_addr[9:0]] <= mem_wd;
  assign mem_rd = mem[mem_addr[9:0]];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input int r, input logic rq, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    if (r == 0) begin
      req0 = rq; we0 = w; addr0 = a; wdata0 = d; be0 = b;
    end else begin
      req1 = rq; we1 = w; addr1 = a; wdata1 = d; be1 = b;
    end
  endtask
  task automatic do_op(input int r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    int wi;
    logic [31:0] nw;
    bit part;
    wi = int'(a[11:2]);
    part = w && b != 4'h0 && b != 4'hF;
    nw = ref_mem[wi];
    for (int i = 0; i < 4; i++) if (b[i]) nw[8*i +: 8] = d[8*i +: 8];
    drive(r, 1'b1, w, a, d, b);
    #1;
    chk("gnt_own", {31'b0, r == 0 ? gnt0 : gnt1}, 32'd1);
    chk("gnt_other", {31'b0, r == 0 ? gnt1 : gnt0}, 32'd0);
    @(negedge clk);
    drive(r, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("acc_we", {31'b0, mem_we}, {31'b0, w && b == 4'hF});
    chk("acc_addr", mem_addr, wi);
    chk("acc_noack", {31'b0, ack0 | ack1}, 32'd0);
    chk("acc_nognt", {31'b0, gnt0 | gnt1}, 32'd0);
    if (w && b == 4'hF) chk("acc_wd", mem_wd, d);
    if (part) begin
      @(negedge clk);
      chk("mrg_we", {31'b0, mem_we}, 32'd1);
      chk("mrg_addr", mem_addr, wi);
      chk("mrg_wd", mem_wd, nw);
      chk("mrg_noack", {31'b0, ack0 | ack1}, 32'd0);
    end
    @(negedge clk);
    if (w) ref_mem[wi] = nw;
    else exp_rd = ref_mem[wi];
    chk("ack_own", {31'b0, r == 0 ? ack0 : ack1}, 32'd1);
    chk("ack_other", {31'b0, r == 0 ? ack1 : ack0}, 32'd0);
    chk("rdata", rdata, exp_rd);
    chk("idle_we", {31'b0, mem_we}, 32'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int lw, next_free, ack_at, ack_who, w;
    logic [31:0] ra [2];
    pl_en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      pl_a = i[9:0];
      pl_d = (i == 28) ? 32'hFFFF_FFFF : $urandom;
      ref_mem[i] = pl_d;
      @(negedge clk);
    end
    pl_en = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h70, 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    #1;
    chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'b0, gnt1}, 32'd0);
    chk("rst_ack", {30'b0, ack0, ack1}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wd", mem_wd, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    do_op(0, 1'b0, 32'h70, 32'h0, 4'hF);
    chk("plan_load70", rdata, 32'hFFFF_FFFF);
    do_op(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    do_op(1, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("plan_full", rdata, 32'hDEAD_BEEF);
    do_op(0, 1'b1, 32'h10, 32'h0000_5500, 4'b0010);
    do_op(0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("plan_merge", rdata, 32'hDEAD_55EF);
    do_op(1, 1'b1, 32'h1010, 32'h1234_5678, 4'h0);
    do_op(1, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("plan_alias", rdata, 32'hDEAD_55EF);
    for (int n = 0; n < 80; n++) begin
      int sel;
      logic [3:0] b;
      sel = $urandom_range(0, 2);
      b = sel == 0 ? 4'hF : sel == 1 ? 4'h0 : 4'($urandom);
      do_op($urandom_range(0, 1), 1'($urandom), $urandom, $urandom, b);
    end
    drive(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'b0101);
    #1;
    chk("rstm_gnt", {31'b0, gnt0}, 32'd1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("rstm_merge_we", {31'b0, mem_we}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rstm_we_drop", {31'b0, mem_we}, 32'd0);
    chk("rstm_noack", {30'b0, ack0, ack1}, 32'd0);
    @(negedge clk);
    chk("rstm_noack2", {30'b0, ack0, ack1}, 32'd0);
    chk("rstm_word", mem[8], ref_mem[8]);
    exp_rd = '0;
    ra[0] = 32'h0000_0070;
    ra[1] = 32'h0000_1044;
    drive(0, 1'b1, 1'b0, ra[0], 32'h0, 4'hF);
    drive(1, 1'b1, 1'b0, ra[1], 32'h0, 4'hF);
    rst = 1'b1;
    lw = 1;
    next_free = 0;
    ack_at = -1;
    ack_who = 0;
    for (int k = 0; k < 14; k++) begin
      logic eg0, eg1, ea0, ea1;
      #1;
      ea0 = ack_at == k && ack_who == 0;
      ea1 = ack_at == k && ack_who == 1;
      if (ea0 || ea1) exp_rd = ref_mem[int'(ra[ack_who][11:2])];
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (k >= next_free) begin
        w = lw == 0 ? 1 : 0;
        lw = w;
        eg0 = w == 0;
        eg1 = w == 1;
        ack_at = k + 2;
        ack_who = w;
        next_free = k + 2;
      end
      chk("rr_gnt0", {31'b0, gnt0}, {31'b0, eg0});
      chk("rr_gnt1", {31'b0, gnt1}, {31'b0, eg1});
      chk("rr_ack0", {31'b0, ack0}, {31'b0, ea0});
      chk("rr_ack1", {31'b0, ack1}, {31'b0, ea1});
      chk("rr_rdata", rdata, exp_rd);
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
